// File: rtl/ikacore_ioctl_pkg.sv
// Shared ioctl-channel definitions for the HPS download/upload helpers:
// slot indices, bus widths and the upload engine state encoding.
package ikacore_ioctl_pkg;

    localparam int IOCTL_ADDR_W = 27;
    localparam int IOCTL_IDX_W  = 16;

    localparam logic [IOCTL_IDX_W-1:0] IDX_ROM   = 16'd0;
    localparam logic [IOCTL_IDX_W-1:0] IDX_DIP   = 16'd254;
    localparam logic [IOCTL_IDX_W-1:0] IDX_NVRAM = 16'd4;

    // Byte returned to HPS for any address the core has no storage behind
    localparam logic [7:0] OOR_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_LAT     = 2'd2,
        ST_PRESENT = 2'd3
    } upl_state_e;

endpackage : ikacore_ioctl_pkg

// File: rtl/ikacore_ioctl_reqpulse.sv
// Rising-edge detector that stretches one accepted edge into a HOLD-clock pulse.
// Edges arriving while blocked or while a pulse is already running are dropped.
module ikacore_ioctl_reqpulse #(
    parameter int HOLD = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    input  logic block_i,
    output logic pulse_o
);

    localparam int CNT_W = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             trig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise;

    assign rise = trig_i & ~trig_q;

    // A running pulse always wins; a new edge is neither extended nor queued
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (rise && !block_i) begin
            cnt_d = HOLD_LOAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trig_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            trig_q <= trig_i;
            cnt_q  <= cnt_d;
        end
    end

    assign pulse_o = (cnt_q != '0);

endmodule : ikacore_ioctl_reqpulse

// File: rtl/ikacore_nvram_uploader.sv
// HPS upload engine: fetches each byte HPS reads from core NVRAM via a req/ack port.
// Define IKACORE_NVRAM_CKSUM_EN to append an XOR checksum byte at address RAM_BYTES.
module ikacore_nvram_uploader
    import ikacore_ioctl_pkg::*;
#(
    parameter int                     ADDR_W       = 11,
    parameter int                     RAM_BYTES    = 2048,
    parameter int                     RD_LATENCY   = 2,
    parameter logic [IOCTL_IDX_W-1:0] UPLOAD_INDEX = IDX_NVRAM,
    parameter int                     REQ_HOLD     = 8
) (
    input  logic                    i_EMU_MCLK,
    input  logic                    i_EMU_INITRST_n,
    input  logic                    i_SAVE_TRIG,
    input  logic                    ioctl_upload,
    input  logic [IOCTL_IDX_W-1:0]  ioctl_index,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic                    ioctl_rd,
    output logic [7:0]              ioctl_din,
    output logic                    ioctl_wait,
    output logic                    ioctl_upload_req,
    output logic                    o_RAM_REQ,
    input  logic                    i_RAM_ACK,
    output logic [ADDR_W-1:0]       o_RAM_ADDR,
    input  logic [7:0]              i_RAM_DATA,
    output logic                    o_BUSY
);

    localparam logic [IOCTL_ADDR_W-1:0] RAM_TOP  = IOCTL_ADDR_W'(RAM_BYTES);
    localparam logic [2:0]              LAT_LOAD = 3'(RD_LATENCY);

    upl_state_e        state_q;
    upl_state_e        state_d;
    logic [7:0]        din_q;
    logic [7:0]        din_d;
    logic              wait_q;
    logic              wait_d;
    logic              req_q;
    logic              req_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        lat_q;
    logic [2:0]        lat_d;

    logic              sel;
    logic              in_range;
    logic              rd_hit;
    logic              rd_oor;
    logic              capture;
    logic              pulse_active;
    logic [7:0]        oor_byte;

    assign sel      = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
    assign in_range = (ioctl_addr < RAM_TOP);
    assign rd_hit   = ioctl_rd & sel & in_range;
    assign rd_oor   = ioctl_rd & sel & ~in_range;
    assign capture  = (state_q == ST_LAT) && (lat_q == '0);

    ikacore_ioctl_reqpulse #(
        .HOLD (REQ_HOLD)
    ) u_reqpulse (
        .clk_i   (i_EMU_MCLK),
        .rst_ni  (i_EMU_INITRST_n),
        .trig_i  (i_SAVE_TRIG),
        .block_i (ioctl_upload),
        .pulse_o (pulse_active)
    );

`ifdef IKACORE_NVRAM_CKSUM_EN
    logic [7:0] cksum_q;
    logic [7:0] cksum_d;
    logic       upload_q;

    // Restart the checksum at each new upload session; every RAM capture folds in
    always_comb begin
        cksum_d = cksum_q;
        if (ioctl_upload && !upload_q) begin
            cksum_d = '0;
        end else if (capture) begin
            cksum_d = cksum_q ^ i_RAM_DATA;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            cksum_q  <= '0;
            upload_q <= 1'b0;
        end else begin
            cksum_q  <= cksum_d;
            upload_q <= ioctl_upload;
        end
    end

    assign oor_byte = (ioctl_addr == RAM_TOP) ? cksum_q : OOR_BYTE;
`else
    assign oor_byte = OOR_BYTE;
`endif

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state_q <= ST_IDLE;
            din_q   <= OOR_BYTE;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
        end
    end

    // Once an access starts it runs to completion even if the session ends
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rd_hit)    state_d = ST_ARB;
            ST_ARB:     if (i_RAM_ACK) state_d = ST_LAT;
            ST_LAT:     if (capture)   state_d = ST_PRESENT;
            ST_PRESENT:                state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        din_d  = din_q;
        wait_d = wait_q;
        req_d  = req_q;
        addr_d = addr_q;
        lat_d  = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_hit) begin
                    addr_d = ioctl_addr[ADDR_W-1:0];
                    req_d  = 1'b1;
                    wait_d = 1'b1;
                end else if (rd_oor) begin
                    din_d = oor_byte;
                end
            end
            ST_ARB: begin
                if (i_RAM_ACK) begin
                    req_d = 1'b0;
                    lat_d = LAT_LOAD;
                end
            end
            ST_LAT: begin
                if (capture) begin
                    din_d = i_RAM_DATA;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ST_PRESENT: begin
                wait_d = 1'b0;
            end
            default: begin
                req_d  = 1'b0;
                wait_d = 1'b0;
            end
        endcase
    end

    assign ioctl_din        = din_q;
    assign ioctl_wait       = wait_q;
    assign ioctl_upload_req = pulse_active;
    assign o_RAM_REQ        = req_q;
    assign o_RAM_ADDR       = addr_q;
    assign o_BUSY           = (state_q != ST_IDLE) | pulse_active;

`ifndef SYNTHESIS
    // HPS must not strobe a new read while the previous one is still stalled
    a_rd_outside_idle: assert property (
        @(posedge i_EMU_MCLK) disable iff (!i_EMU_INITRST_n)
        !(ioctl_rd && (state_q != ST_IDLE))
    );
`endif

endmodule : ikacore_nvram_uploader

// File: tb/tb_ikacore_nvram_uploader.sv
// Directed bench for ikacore_nvram_uploader with a req/ack NVRAM model.
// Checksum steps run only when IKACORE_NVRAM_CKSUM_EN is defined.
module tb_ikacore_nvram_uploader;

    localparam int RD_LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        i_SAVE_TRIG;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;
    logic        o_RAM_REQ;
    logic        i_RAM_ACK;
    logic [10:0] o_RAM_ADDR;
    logic [7:0]  i_RAM_DATA;
    logic        o_BUSY;

    logic [7:0]  ram [0:2047];
    int          ackDelay;
    int          vecCount;
    int          missCount;

    ikacore_nvram_uploader dut (
        .i_EMU_MCLK       (clk),
        .i_EMU_INITRST_n  (rst_n),
        .i_SAVE_TRIG      (i_SAVE_TRIG),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_addr       (ioctl_addr),
        .ioctl_rd         (ioctl_rd),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait),
        .ioctl_upload_req (ioctl_upload_req),
        .o_RAM_REQ        (o_RAM_REQ),
        .i_RAM_ACK        (i_RAM_ACK),
        .o_RAM_ADDR       (o_RAM_ADDR),
        .i_RAM_DATA       (i_RAM_DATA),
        .o_BUSY           (o_BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // NVRAM arbiter model: grants after ackDelay cycles of request, then drives
    // a poisoned byte until RD_LATENCY cycles after the grant edge
    initial begin
        int ackWait;
        int dataCountdown;
        logic [10:0] ackAddr;
        ackWait = 0;
        dataCountdown = 0;
        ackAddr = '0;
        i_RAM_ACK = 1'b0;
        i_RAM_DATA = 8'h00;
        forever begin
            @(negedge clk);
            i_RAM_ACK = 1'b0;
            if (dataCountdown > 0) begin
                dataCountdown--;
                if (dataCountdown == 0) i_RAM_DATA = ram[ackAddr];
            end
            if (o_RAM_REQ === 1'b1) begin
                if (ackWait >= ackDelay) begin
                    i_RAM_ACK = 1'b1;
                    ackAddr = o_RAM_ADDR;
                    i_RAM_DATA = ~ram[o_RAM_ADDR];
                    dataCountdown = RD_LATENCY;
                    ackWait = 0;
                end else begin
                    ackWait++;
                end
            end else begin
                ackWait = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [26:0] addr, input int delay,
                                 input bit dropUpload, output int waitCycles,
                                 output int reqCycles, output logic [10:0] reqAddr,
                                 output bit timedOut);
        ackDelay = delay;
        @(negedge clk);
        ioctl_addr = addr;
        ioctl_rd = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        waitCycles = 0;
        reqCycles = 0;
        reqAddr = '0;
        while (ioctl_wait === 1'b1 && waitCycles < 200) begin
            if (o_RAM_REQ === 1'b1) begin
                if (reqCycles == 0) reqAddr = o_RAM_ADDR;
                reqCycles++;
            end
            waitCycles++;
            if (dropUpload && waitCycles == 1) ioctl_upload = 1'b0;
            @(negedge clk);
        end
        if (o_RAM_REQ === 1'b1) reqCycles++;
        timedOut = (waitCycles >= 200);
    endtask

    initial begin
        int w;
        int rq;
        int pulseCount;
        int timeouts;
        int dataErr;
        logic [10:0] ra;
        bit to;
        logic busyInPulse;
        logic [26:0] oorAddr;

        vecCount = 0;
        missCount = 0;
        ackDelay = 0;
        rst_n = 1'b0;
        i_SAVE_TRIG = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index = 16'd0;
        ioctl_addr = '0;
        ioctl_rd = 1'b0;
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'h3C;
        ram[11'h123] = 8'h5A;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        checkOutput("rst_din", ioctl_din, 8'hFF);
        checkOutput("rst_wait", ioctl_wait, 1'b0);
        checkOutput("rst_upload_req", ioctl_upload_req, 1'b0);
        checkOutput("rst_ram_req", o_RAM_REQ, 1'b0);
        checkOutput("rst_ram_addr", o_RAM_ADDR, 11'h000);
        checkOutput("rst_busy", o_BUSY, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Save trigger: 8-clock pulse, a second edge mid-pulse is dropped
        pulseCount = 0;
        busyInPulse = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ioctl_upload_req === 1'b1) pulseCount++;
            if (i == 1) busyInPulse = o_BUSY;
            if (i == 0) i_SAVE_TRIG = 1'b1;
            if (i == 2) i_SAVE_TRIG = 1'b0;
            if (i == 3) i_SAVE_TRIG = 1'b1;
            if (i == 10) i_SAVE_TRIG = 1'b0;
        end
        checkOutput("trig_pulse_len", pulseCount, 8);
        checkOutput("trig_busy", busyInPulse, 1'b1);

        // Edge during an active upload is ignored and not replayed later
        ioctl_upload = 1'b1;
        ioctl_index = 16'd4;
        pulseCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ioctl_upload_req === 1'b1) pulseCount++;
            if (i == 2) i_SAVE_TRIG = 1'b1;
            if (i == 6) ioctl_upload = 1'b0;
        end
        i_SAVE_TRIG = 1'b0;
        checkOutput("trig_during_upload", pulseCount, 0);
        ioctl_upload = 1'b1;
        @(negedge clk);

        // Basic read with immediate grant
        applyStimulus(27'h123, 0, 1'b0, w, rq, ra, to);
        checkOutput("basic_timeout", to, 1'b0);
        checkOutput("basic_wait_cycles", w, 5);
        checkOutput("basic_req_cycles", rq, 1);
        checkOutput("basic_ram_addr", ra, 11'h123);
        checkOutput("basic_din", ioctl_din, 8'h5A);
        checkOutput("basic_busy_after", o_BUSY, 1'b0);

        // High address bits set: out of range, no RAM access
        applyStimulus(27'h4000123, 0, 1'b0, w, rq, ra, to);
        checkOutput("hibits_wait_cycles", w, 0);
        checkOutput("hibits_req_cycles", rq, 0);
        checkOutput("hibits_din", ioctl_din, 8'hFF);

        // Arbitration stall of 20 cycles on the last valid byte
        applyStimulus(27'h7FF, 20, 1'b0, w, rq, ra, to);
        checkOutput("stall_timeout", to, 1'b0);
        checkOutput("stall_wait_cycles", w, 25);
        checkOutput("stall_req_cycles", rq, 21);
        checkOutput("stall_ram_addr", ra, 11'h7FF);
        checkOutput("stall_din", ioctl_din, 8'hC3);

        // Wrong index: read ignored, din keeps the last byte
        ioctl_index = 16'd0;
        applyStimulus(27'h010, 0, 1'b0, w, rq, ra, to);
        checkOutput("wrongidx_wait_cycles", w, 0);
        checkOutput("wrongidx_req_cycles", rq, 0);
        checkOutput("wrongidx_din", ioctl_din, 8'hC3);
        ioctl_index = 16'd4;

        // First out-of-range address (the checksum build owns address 2048)
`ifdef IKACORE_NVRAM_CKSUM_EN
        oorAddr = 27'd2049;
`else
        oorAddr = 27'd2048;
`endif
        applyStimulus(oorAddr, 0, 1'b0, w, rq, ra, to);
        checkOutput("oor_wait_cycles", w, 0);
        checkOutput("oor_req_cycles", rq, 0);
        checkOutput("oor_din", ioctl_din, 8'hFF);

        // Reset asserted while the access sits in the latency state
        ackDelay = 0;
        @(negedge clk);
        ioctl_addr = 27'h055;
        ioctl_rd = 1'b1;
        @(negedge clk);
        ioctl_rd = 1'b0;
        @(negedge clk);
        checkOutput("midrst_wait_before", ioctl_wait, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_din", ioctl_din, 8'hFF);
        checkOutput("midrst_wait", ioctl_wait, 1'b0);
        checkOutput("midrst_ram_req", o_RAM_REQ, 1'b0);
        checkOutput("midrst_ram_addr", o_RAM_ADDR, 11'h000);
        checkOutput("midrst_busy", o_BUSY, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(27'h055, 0, 1'b0, w, rq, ra, to);
        checkOutput("postrst_wait_cycles", w, 5);
        checkOutput("postrst_din", ioctl_din, 8'h69);

        // Upload session ends mid-access: the access still completes cleanly
        applyStimulus(27'h200, 3, 1'b1, w, rq, ra, to);
        checkOutput("dropup_wait_cycles", w, 8);
        checkOutput("dropup_din", ioctl_din, 8'h3C);
        @(negedge clk);
        checkOutput("dropup_wait_after", ioctl_wait, 1'b0);
        checkOutput("dropup_busy_after", o_BUSY, 1'b0);

`ifdef IKACORE_NVRAM_CKSUM_EN
        // Full sequential upload with RAM = address[7:0]: XOR trailer is 00
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) ram[5] = 8'h05 ^ 8'h01;
            ioctl_upload = 1'b0;
            @(negedge clk);
            ioctl_upload = 1'b1;
            @(negedge clk);
            timeouts = 0;
            dataErr = 0;
            for (int a = 0; a < 2048; a++) begin
                applyStimulus(27'(a), 0, 1'b0, w, rq, ra, to);
                if (to) timeouts++;
                if (ioctl_din !== ram[a]) dataErr++;
            end
            checkOutput("cksum_timeouts", timeouts, 0);
            checkOutput("cksum_data_errs", dataErr, 0);
            applyStimulus(27'd2048, 0, 1'b0, w, rq, ra, to);
            checkOutput("cksum_trailer_wait", w, 0);
            checkOutput("cksum_trailer", ioctl_din, (pass == 0) ? 8'h00 : 8'h01);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule : tb_ikacore_nvram_uploader

// File: doc/ikacore_nvram_uploader.md
Name: ikacore_nvram_uploader

Overview:
- Serves the HPS "upload" direction of the ioctl channel; the ROM download path is the opposite direction.
- On a save trigger, raises ioctl_upload_req. HPS then issues byte read strobes, and this block fetches each requested byte from core-side NVRAM/hiscore RAM through a request/acknowledge port.
- Presents each byte on ioctl_din and stretches ioctl_wait until the byte is valid.
- Sits in the game board top, beside the download loader, between the hps_io ioctl signals and the NVRAM arbiter.

Parameters:
- ADDR_W, 11, NVRAM byte-address width.
- RAM_BYTES, 2048, number of valid NVRAM bytes; must be <= 2^ADDR_W.
- RD_LATENCY, 2, cycles from i_RAM_ACK to valid i_RAM_DATA; range 1..7.
- UPLOAD_INDEX, 16'h0004, ioctl_index value that selects this block.
- REQ_HOLD, 8, length of the ioctl_upload_req pulse in clocks.

Ports:
- i_EMU_MCLK  in  1  master clock, 60 MHz.
- i_EMU_INITRST_n  in  1  asynchronous, active-low reset.
- i_SAVE_TRIG  in  1  save request, rising-edge sensitive.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  16  selected ioctl slot.
- ioctl_addr  in  27  byte address of the current read.
- ioctl_rd  in  1  one-cycle read strobe.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stall to HPS.
- ioctl_upload_req  out  1  asks HPS to start an upload.
- o_RAM_REQ  out  1  NVRAM access request.
- i_RAM_ACK  in  1  one-cycle grant; the address is sampled on this cycle.
- o_RAM_ADDR  out  ADDR_W  NVRAM address.
- i_RAM_DATA  in  8  NVRAM read data.
- o_BUSY  out  1  high in any state other than IDLE, or while a request pulse is active.

Behaviour:
- Reset (async assert, sync release) values: ioctl_din=8'hFF, ioctl_wait=0, ioctl_upload_req=0, o_RAM_REQ=0, o_RAM_ADDR=0, o_BUSY=0; FSM=IDLE; counters=0.
- sel = ioctl_upload & (ioctl_index == UPLOAD_INDEX).
- Trigger:
  - A rising edge of i_SAVE_TRIG while !ioctl_upload loads the pulse counter with REQ_HOLD.
  - ioctl_upload_req stays high while the counter is nonzero.
  - An edge during an active pulse or an active upload is ignored and not queued.
- FSM states: IDLE, ARB, LAT, PRESENT.
- IDLE:
  - On ioctl_rd & sel with ioctl_addr < RAM_BYTES: latch o_RAM_ADDR = ioctl_addr[ADDR_W-1:0]; set o_RAM_REQ=1 and ioctl_wait=1 in the same edge; go to ARB.
  - On ioctl_rd & sel with ioctl_addr >= RAM_BYTES (out of range): ioctl_din=8'hFF on the next cycle, no RAM access, no wait.
  - ioctl_rd without sel is ignored.
- ARB:
  - Hold o_RAM_REQ until i_RAM_ACK.
  - On i_RAM_ACK: drop o_RAM_REQ, load the latency counter with RD_LATENCY, go to LAT.
- LAT:
  - Decrement the latency counter; at 0, capture i_RAM_DATA into ioctl_din and go to PRESENT.
- PRESENT:
  - Drop ioctl_wait, return to IDLE.
- Minimum read turnaround, from the ioctl_rd edge to ioctl_wait low: RD_LATENCY + 3 cycles with ACK immediate.
- ioctl_din holds its value until the next completed read.
- An ioctl_rd received outside IDLE is a protocol violation: ignore it and flag it with a sim assertion.
- ioctl_upload falling mid-access: finish the access, keep ioctl_din, go to IDLE; no ioctl_wait glitch.
- Address wrap: none. ioctl_addr is compared with full 27-bit width, so high bits set are treated as out of range.
- Reset mid-access: o_RAM_REQ drops asynchronously; the arbiter must tolerate a withdrawn request.

Optional Feature:
- Macro: IKACORE_NVRAM_CKSUM_EN.
- Enabled:
  - An 8-bit XOR accumulator clears when ioctl_upload rises.
  - It XORs each byte captured from RAM.
  - A read at ioctl_addr == RAM_BYTES returns the accumulator instead of 8'hFF, so the upload is RAM_BYTES+1 bytes.
  - A re-read of the same address also accumulates; HPS is required to read sequentially.
- Disabled: no accumulator logic; address RAM_BYTES returns 8'hFF like any other out-of-range address.

Decomposition:
- Shared package ikacore_ioctl_pkg:
  - typedef of the FSM state enum.
  - IOCTL_ADDR_W=27 and IOCTL_IDX_W=16.
  - Index constants: ROM=0, DIP=254, NVRAM=4.
  - OOR_BYTE=8'hFF.
- Sub-module ikacore_ioctl_reqpulse: edge detector plus REQ_HOLD pulse stretcher, reused by the download side for its done strobe.

Test Plan:
- Trigger: i_SAVE_TRIG 0→1 with ioctl_upload=0 → ioctl_upload_req high exactly 8 clocks; a second edge during the pulse does not extend it.
- Basic read: RAM[0x123]=8'h5A; index 4, upload=1, rd at addr 0x123, ACK same cycle → o_RAM_ADDR=0x123, ioctl_wait high 5 cycles, ioctl_din=8'h5A.
- Arbitration stall: ACK delayed 20 cycles → o_RAM_REQ and ioctl_wait held for the whole wait, data correct afterwards.
- Out of range and wrong index: rd at addr 2048 → din=8'hFF with wait never high; rd with index 0 → no RAM_REQ and din unchanged.
- Reset mid-access: assert i_EMU_INITRST_n=0 in LAT → all outputs at reset values immediately; the next read completes normally.
- CKSUM_EN: sequential upload of bytes 0..2047 with RAM = address[7:0] → the byte at address 2048 reads 8'h00; with one byte flipped to 8'h01 ^ original → the checksum equals 8'h01.
